// File: rtl/dbg_pkg.sv
// dbg_pkg: shared state encoding, default parameters and latency-pipeline entry type for dbg_rd_port
package dbg_pkg;
  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 16;
  localparam int N_CH_DEF    = 2;
  localparam int MEM_LAT_DEF = 1;
  localparam int LEN_W_DEF   = 2;
  // Channel index width sized for the largest supported channel count (8).
  localparam int CH_W        = 3;
  typedef enum logic {IDLE, BURST} state_t;
  typedef struct packed {
    logic            v;
    logic [CH_W-1:0] ch;
    logic            last;
  } pipe_t;
endpackage

// File: rtl/dbg_rr_arb.sv
// dbg_rr_arb: N_CH round-robin arbiter; one-hot grant plus its index, pointer moves only on advance_i
//   clk, rst    : clock, synchronous active-high reset (channel 0 gets first priority)
//   req_i       : per-channel requests
//   advance_i   : grant was accepted this cycle
//   gnt_o/idx_o : one-hot grant and its binary index
module dbg_rr_arb import dbg_pkg::*; #(
  parameter int N_CH = N_CH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req_i,
  input  logic            advance_i,
  output logic [N_CH-1:0] gnt_o,
  output logic [CH_W-1:0] idx_o
);
  logic [CH_W-1:0] ptr_q, ptr_d;
  // Walk from the farthest candidate to the nearest so the channel right after ptr_q wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int k = N_CH; k >= 1; k--) begin
      if (req_i[(int'(ptr_q) + k) % N_CH]) begin
        gnt_o = '0;
        gnt_o[(int'(ptr_q) + k) % N_CH] = 1'b1;
        idx_o = CH_W'((int'(ptr_q) + k) % N_CH);
      end
    end
  end
  always_comb ptr_d = advance_i ? idx_o : ptr_q;
  always_ff @(posedge clk)
    if (rst) ptr_q <= CH_W'(N_CH - 1);
    else     ptr_q <= ptr_d;
endmodule

// File: rtl/dbg_rd_port.sv
// dbg_rd_port: arbitrated burst reads of the CPU data memory through its shared read port, CPU first
//   req_valid/req_addr/req_len/req_ready : per-channel burst requests (len = words-1), one-hot grant
//   cpu_busy                             : CPU owns the memory port this cycle, stalls issue
//   mem_rd/mem_addr/mem_rdata            : memory read port, data returns MEM_LAT cycles after mem_rd
//   resp_valid/resp_data/resp_last       : one-hot response, shared data, end-of-burst marker
module dbg_rd_port import dbg_pkg::*; #(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int N_CH    = N_CH_DEF,
  parameter int MEM_LAT = MEM_LAT_DEF,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  logic                   clk,
  input  logic                   ext_rst,
  input  logic [N_CH-1:0]        req_valid,
  input  logic [N_CH*ADDR_W-1:0] req_addr,
  input  logic [N_CH*LEN_W-1:0]  req_len,
  output logic [N_CH-1:0]        req_ready,
  input  logic                   cpu_busy,
  output logic                   mem_rd,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic [N_CH-1:0]        resp_valid,
  output logic [DATA_W-1:0]      resp_data,
  output logic                   resp_last
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [N_CH-1:0]   gnt;
  logic [CH_W-1:0]   gnt_idx;
  logic              grant, issue;
  pipe_t             pipe_q [MEM_LAT];
  pipe_t             tail;
  assign grant = (state_q == IDLE) && |req_valid;
  assign issue = (state_q == BURST) && !cpu_busy;
  dbg_rr_arb #(.N_CH(N_CH)) u_arb (
    .clk       (clk),
    .rst       (ext_rst),
    .req_i     (req_valid),
    .advance_i (grant),
    .gnt_o     (gnt),
    .idx_o     (gnt_idx)
  );
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    ch_d        = ch_q;
    if (grant) begin
      cur_addr_d  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
      remaining_d = req_len[int'(gnt_idx)*LEN_W +: LEN_W];
      ch_d        = gnt_idx;
      state_d     = BURST;
    end
    if (issue) begin
      cur_addr_d  = cur_addr_q + ADDR_W'(1);
      remaining_d = remaining_q - LEN_W'(1);
      state_d     = (remaining_q == '0) ? IDLE : BURST;
    end
  end
  always_ff @(posedge clk)
    if (ext_rst) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      ch_q        <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      ch_q        <= ch_d;
    end
  // Latency pipeline shifts every cycle; a stall simply inserts an empty slot.
  always_ff @(posedge clk)
    if (ext_rst) begin
      for (int i = 0; i < MEM_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= '{v: issue, ch: ch_q, last: remaining_q == '0};
      for (int i = 1; i < MEM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  assign tail       = pipe_q[MEM_LAT-1];
  assign req_ready  = grant ? gnt : '0;
  assign mem_rd     = issue;
  assign mem_addr   = cur_addr_q;
  assign resp_valid = tail.v ? N_CH'(1) << tail.ch : '0;
  assign resp_data  = tail.v ? mem_rdata : '0;
  assign resp_last  = tail.v && tail.last;
endmodule

// File: doc/dbg_rd_port.md
# dbg_rd_port

Parametrised debug read port that lets up to N_CH external requesters (bench readback, trace logic, future UART monitor) read the CPU data memory through its shared read port. It generalises the single-shot rd/raddr/rdata access into arbitrated, burst-capable, latency-configurable reads. The CPU always has priority on the memory port. The block sits in top beside the data memory, between the debug requesters and the memory read port.

## Interface
Parameters:
- ADDR_W, 8, memory word-address width
- DATA_W, 16, memory word width
- N_CH, 2, number of requester channels (1..8)
- MEM_LAT, 1, memory read latency in cycles, from mem_rd to mem_rdata valid (1..4)
- LEN_W, 2, burst-length field width; a burst is req_len+1 words

Ports:
- clk  in  1  clock; all logic on the rising edge
- ext_rst  in  1  reset; synchronous, active-high
- req_valid  in  N_CH  per-channel request valid
- req_addr  in  N_CH*ADDR_W  per-channel start address; channel i uses bits [i*ADDR_W +: ADDR_W]
- req_len  in  N_CH*LEN_W  per-channel burst length minus 1
- req_ready  out  N_CH  one-hot grant pulse; a request is accepted when valid&ready
- cpu_busy  in  1  CPU is using the memory read port this cycle
- mem_rd  out  1  memory read strobe
- mem_addr  out  ADDR_W  memory read address
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_rd
- resp_valid  out  N_CH  one-hot response valid; there is no backpressure
- resp_data  out  DATA_W  response word, shared across channels
- resp_last  out  1  marks the final word of a burst

## Operation
- The FSM has two states, IDLE and BURST.
- IDLE:
  - If any req_valid is high, the round-robin arbiter picks a channel. Search starts at the channel after the last granted one; after reset it starts at channel 0.
  - The block asserts req_ready for that channel for one cycle.
  - It latches the channel's addr and len into cur_addr and remaining, then moves to BURST.
- BURST, each cycle:
  - If cpu_busy=0: mem_rd=1 and mem_addr=cur_addr. cur_addr increments modulo 2^ADDR_W (0xFF wraps to 0x00). remaining decrements. The issue that has remaining==0 is the last one and returns the FSM to IDLE.
  - If cpu_busy=1: mem_rd=0, and cur_addr and remaining hold.
- Each issue pushes {valid, channel, last} into a MEM_LAT-deep shift pipeline. The pipeline advances every cycle regardless of cpu_busy.
- At the pipeline tail: resp_valid[channel]=1, resp_data=mem_rdata, resp_last=last.
- req_valid dropping while in BURST has no effect; the accepted burst completes.
- Requests arriving in BURST wait until IDLE. The ready/valid pair is the only acceptance point.
- cpu_busy high in the same cycle as a grant: the grant still happens, and the first issue stalls.

## Timing
- Reset: req_ready=0, mem_rd=0, mem_addr=0, resp_valid=0, resp_data=0, resp_last=0. FSM goes to IDLE, the RR pointer is set so channel 0 has priority, and the pipeline is flushed.
- Reset mid-burst: in-flight reads are discarded and no response is emitted for them.
- Grant in cycle t. First mem_rd in t+1 (no stall). First resp_valid in t+1+MEM_LAT. Consecutive words follow back-to-back when cpu_busy=0.
- Last issue in cycle u puts the FSM in IDLE at u+1. The next grant is no earlier than u+1 and its first issue no earlier than u+2, so there is exactly one bubble between bursts.
- Responses from different channels never overlap. Order matches issue order.
- Throughput is at most one word per cycle.

## Structure
- Package dbg_pkg holds the FSM state encoding (IDLE, BURST) and the default parameter constants.
- Sub-module dbg_rr_arb is an N_CH round-robin arbiter with inputs req and advance, and output a one-hot grant. Its pointer updates only on an accepted grant.
- The latency pipeline is inline: MEM_LAT registers of {valid, ch, last}.

## Test plan
Bench memory model returns mem_rdata = {8'hA5, addr} after MEM_LAT cycles.
- Single read: ch0 addr=0x10, len=0, MEM_LAT=1. Expect req_ready[0] at t, mem_rd at t+1, resp_valid[0] at t+2 with data 0xA510 and resp_last=1.
- Burst with wrap: ch1 addr=0xFE, len=3. Expect mem_addr FE, FF, 00, 01 on consecutive cycles, responses 0xA5FE, 0xA5FF, 0xA500, 0xA501, and resp_last on the fourth word only.
- Round-robin: ch0 and ch1 both hold valid continuously with len=0. Expect grants alternating 0, 1, 0, 1, and each grant no earlier than the cycle after the previous burst's last issue.
- CPU priority: cpu_busy high for 2 cycles in the middle of a len=3 burst. Expect mem_rd low for those 2 cycles, no address skipped, and 4 responses in order.
- Latency sweep: MEM_LAT=4, single read. Expect resp_valid exactly 5 cycles after req_ready.
- Reset mid-burst: ext_rst high for 1 cycle after the 2nd issue of a len=3 burst. Expect all outputs 0 the following cycle, no stale resp_valid afterwards, and channel 0 winning the next simultaneous request.
